// File: rtl/reg_wb_arbiter.sv
// Merges ALU and load writebacks into one register-file write port through an in-order queue.
// Latency: one cycle from accept to write; READY reflects start-of-cycle occupancy only.
module reg_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG,
  input  logic [63:0] A_DATA,
  output logic        A_READY,
  input  logic        B_VALID,
  input  logic [4:0]  B_REG,
  input  logic [63:0] B_DATA,
  output logic        B_READY,
  output logic        REG_WRITE_ENABLE,
  output logic [4:0]  WRITE_REG,
  output logic [63:0] WRITE_DATA,
  output logic [31:0] PENDING_MASK,
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] b_slot;
  logic [AW-1:0] off;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] need_b;
  logic [4:0]    q_reg  [DEPTH];
  logic [63:0]   q_data [DEPTH];
  logic          busy;
  logic          a_live;
  logic          push_a;
  logic          push_b;
  logic [31:0]   pending;

  assign busy       = (count != '0);
  assign a_live     = A_VALID && (A_REG != 5'd0);
  assign free_slots = FULL - count;
  // B must leave room for a live A request, which always goes in first
  assign need_b     = a_live ? CW'(2) : CW'(1);

  assign A_READY = !RESET && (count < FULL);
  assign B_READY = !RESET && (free_slots >= need_b);

  // Register-0 requests handshake normally but never occupy a slot
  assign push_a = a_live && A_READY;
  assign push_b = B_VALID && B_READY && (B_REG != 5'd0);
  assign b_slot = wr_ptr + AW'(push_a);

  assign REG_WRITE_ENABLE = busy;
  assign BUSY             = busy;
  assign WRITE_REG        = busy ? q_reg[rd_ptr]  : 5'd0;
  assign WRITE_DATA       = busy ? q_data[rd_ptr] : 64'd0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
      rd_ptr <= rd_ptr + AW'(busy);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(busy);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_a) begin
      q_reg[wr_ptr]  <= A_REG;
      q_data[wr_ptr] <= A_DATA;
    end
    if (push_b) begin
      q_reg[b_slot]  <= B_REG;
      q_data[b_slot] <= B_DATA;
    end
  end

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    pending = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count) pending[q_reg[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign PENDING_MASK = pending;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector table plus randomized traffic checked against a queue-based reference model.
module tb_reg_wb_arbiter;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_VALID;
  logic [4:0]  A_REG;
  logic [63:0] A_DATA;
  logic        A_READY;
  logic        B_VALID;
  logic [4:0]  B_REG;
  logic [63:0] B_DATA;
  logic        B_READY;
  logic        REG_WRITE_ENABLE;
  logic [4:0]  WRITE_REG;
  logic [63:0] WRITE_DATA;
  logic [31:0] PENDING_MASK;
  logic        BUSY;

  reg_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(B_READY),
    .REG_WRITE_ENABLE(REG_WRITE_ENABLE), .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
    .PENDING_MASK(PENDING_MASK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ar;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [63:0] bd;
    logic        x_ar;
    logic        x_br;
    logic        x_we;
    logic [4:0]  x_reg;
    logic [63:0] x_dat;
    logic [31:0] x_pend;
  } vec_t;

  ent_t        q[$];
  logic [63:0] rf_ref [32];
  logic [63:0] rf_dut [32];
  int          total = 0;
  int          bad = 0;

  logic        m_ar, m_br, m_we;
  logic [4:0]  m_reg;
  logic [63:0] m_dat;
  logic [31:0] m_pend;

  function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ar,
                              input logic [63:0] ad, input logic bv, input logic [4:0] br,
                              input logic [63:0] bd, input logic x_ar, input logic x_br,
                              input logic x_we, input logic [4:0] x_reg,
                              input logic [63:0] x_dat, input logic [31:0] x_pend);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.x_ar = x_ar; v.x_br = x_br; v.x_we = x_we; v.x_reg = x_reg; v.x_dat = x_dat;
    v.x_pend = x_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, let them settle, and compute what the model expects this cycle
  task automatic drive(input logic rst, input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic bv, input logic [4:0] br, input logic [63:0] bd);
    int sz;
    RESET = rst; A_VALID = av; A_REG = ar; A_DATA = ad;
    B_VALID = bv; B_REG = br; B_DATA = bd;
    #4;
    sz = q.size();
    m_ar = !rst && (sz < DEPTH);
    m_br = !rst && ((DEPTH - sz) >= (1 + ((av && ar != 5'd0) ? 1 : 0)));
    m_we = (sz != 0);
    m_reg = 5'd0;
    m_dat = 64'd0;
    if (sz != 0) begin
      m_reg = q[0].r;
      m_dat = q[0].d;
    end
    m_pend = '0;
    foreach (q[k]) m_pend[q[k].r] = 1'b1;
    if (REG_WRITE_ENABLE === 1'b1) rf_dut[WRITE_REG] = WRITE_DATA;
  endtask

  task automatic advance();
    logic a_acc, b_acc;
    ent_t e;
    a_acc = A_VALID && m_ar;
    b_acc = B_VALID && m_br;
    @(posedge CLK);
    if (q.size() != 0) begin
      rf_ref[q[0].r] = q[0].d;
      void'(q.pop_front());
    end
    if (RESET) begin
      q.delete();
    end else begin
      if (a_acc && A_REG != 5'd0) begin e.r = A_REG; e.d = A_DATA; q.push_back(e); end
      if (b_acc && B_REG != 5'd0) begin e.r = B_REG; e.d = B_DATA; q.push_back(e); end
    end
    #1;
  endtask

  task automatic check_model(input int c);
    chk($sformatf("r%0d_a_ready", c), 64'(A_READY), 64'(m_ar));
    chk($sformatf("r%0d_b_ready", c), 64'(B_READY), 64'(m_br));
    chk($sformatf("r%0d_we", c), 64'(REG_WRITE_ENABLE), 64'(m_we));
    chk($sformatf("r%0d_busy", c), 64'(BUSY), 64'(m_we));
    chk($sformatf("r%0d_wreg", c), 64'(WRITE_REG), 64'(m_reg));
    chk($sformatf("r%0d_wdata", c), WRITE_DATA, m_dat);
    chk($sformatf("r%0d_pending", c), 64'(PENDING_MASK), 64'(m_pend));
  endtask

  vec_t tbl [21];

  initial begin
    logic        rst, av, bv, ah, bh;
    logic [4:0]  ar, br;
    logic [63:0] ad, bd;

    foreach (rf_ref[r]) begin
      rf_ref[r] = '0;
      rf_dut[r] = '0;
    end

    //        rst av ar  ad        bv br  bd        ar br we reg dat       pend
    tbl[0]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[1]  = mk(0, 1, 3,  'h1234,   0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[2]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 3,  'h1234,   'h8);
    tbl[3]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[4]  = mk(0, 1, 1,  'hA,      1, 2,  'hB,      1, 1, 0, 0,  0,        0);
    tbl[5]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 1,  'hA,      'h6);
    tbl[6]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 2,  'hB,      'h4);
    tbl[7]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[8]  = mk(0, 1, 5,  'h1,      0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[9]  = mk(0, 0, 0,  0,        1, 5,  'h2,      1, 1, 1, 5,  'h1,      'h20);
    tbl[10] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 5,  'h2,      'h20);
    tbl[11] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[12] = mk(0, 1, 0,  'hFF,     0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[13] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[14] = mk(0, 1, 6,  'h60,     1, 7,  'h70,     1, 1, 0, 0,  0,        0);
    tbl[15] = mk(0, 1, 8,  'h80,     1, 9,  'h90,     1, 1, 1, 6,  'h60,     'hC0);
    tbl[16] = mk(0, 1, 10, 'hA0,     1, 11, 'hB0,     1, 0, 1, 7,  'h70,     'h380);
    tbl[17] = mk(0, 1, 0,  'hFF,     1, 11, 'hB0,     1, 1, 1, 8,  'h80,     'h700);
    tbl[18] = mk(1, 1, 12, 'hC0,     0, 0,  0,        0, 0, 1, 9,  'h90,     'hE00);
    tbl[19] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);
    tbl[20] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  0,        0);

    drive(1, 0, 0, 0, 0, 0, 0);
    advance();
    drive(1, 0, 0, 0, 0, 0, 0);
    advance();

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
      chk($sformatf("v%0d_a_ready", i), 64'(A_READY), 64'(tbl[i].x_ar));
      chk($sformatf("v%0d_b_ready", i), 64'(B_READY), 64'(tbl[i].x_br));
      chk($sformatf("v%0d_we", i), 64'(REG_WRITE_ENABLE), 64'(tbl[i].x_we));
      chk($sformatf("v%0d_busy", i), 64'(BUSY), 64'(tbl[i].x_we));
      chk($sformatf("v%0d_wreg", i), 64'(WRITE_REG), 64'(tbl[i].x_reg));
      chk($sformatf("v%0d_wdata", i), WRITE_DATA, tbl[i].x_dat);
      chk($sformatf("v%0d_pending", i), 64'(PENDING_MASK), 64'(tbl[i].x_pend));
      advance();
    end

    // Random traffic; a refused request is held stable until accepted
    ah = 1'b0; bh = 1'b0;
    av = 1'b0; ar = '0; ad = '0; bv = 1'b0; br = '0; bd = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!ah) begin
        av = ($urandom_range(0, 9) < 7);
        ar = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        ad = {$urandom, $urandom};
      end
      if (!bh) begin
        bv = ($urandom_range(0, 9) < 7);
        br = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        bd = {$urandom, $urandom};
      end
      drive(rst, av, ar, ad, bv, br, bd);
      check_model(c);
      ah = av && !m_ar && !rst;
      bh = bv && !m_br && !rst;
      advance();
    end

    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check_model(3000 + c);
      advance();
    end

    for (int r = 0; r < 32; r++) begin
      chk($sformatf("rf%0d_final", r), rf_dut[r], rf_ref[r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
